// File: rtl/posit_mult_scheduler_if.sv
// Requester and response handshake bundle for the posit multiplier scheduler.
// Both channels are valid/ready: a beat moves on a rising clk edge where the
// sender's valid and the receiver's ready are both high; the sender holds
// valid and payload stable until that edge.
interface posit_mult_scheduler_if #(
  parameter int N    = 32,
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*N-1:0] req_a;
  logic [NREQ*N-1:0] req_b;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [N-1:0]      rsp_data;
  logic [IDW-1:0]    rsp_id;

  // Requesters and the response consumer.
  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id
  );

  // The scheduler.
  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id
  );
endinterface

// File: rtl/posit_mult_scheduler.sv
// Round-robin scheduler sharing one fixed-latency posit multiplier datapath
// between NREQ requesters. Tracks in-flight tags alongside the datapath and
// buffers products in an in-order result FIFO guarded by a credit counter, so
// the FIFO can never be asked to take more than it can hold.
module posit_mult_scheduler #(
  parameter int N    = 32,
  parameter int NREQ = 4,
  parameter int LAT  = 2,
  parameter int FD   = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  posit_mult_scheduler_if.slave  bus,
  output logic                   mul_valid,
  output logic [N-1:0]           mul_a,
  output logic [N-1:0]           mul_b,
  input  logic [N-1:0]           mul_result,
  output logic                   busy
);

  localparam int CW = $clog2(FD + 1);
  localparam int PW = (FD > 1) ? $clog2(FD) : 1;

  // Arbitration
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [NREQ-1:0] grant_oh;
  logic [IDW-1:0]  grant_id;
  logic            grant_found;
  int              arb_idx;
  logic [CW:0]     credit_sum;
  logic            credit_ok;
  logic            accept;
  logic [N-1:0]    grant_a, grant_b;

  // Issue stage
  logic            mul_valid_q;
  logic [N-1:0]    mul_a_q, mul_b_q;
  logic [IDW-1:0]  mul_id_q;

  // Tag pipeline shadowing the datapath
  logic [LAT-1:0]  tag_v_q;
  logic [IDW-1:0]  tag_id_q [LAT];
  logic            tag_out_v;
  logic [IDW-1:0]  tag_out_id;

  // Counters
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   fifo_count_q, fifo_count_d;

  // Result FIFO
  logic [N-1:0]    fifo_data_q [FD];
  logic [IDW-1:0]  fifo_id_q [FD];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic            fifo_wr, fifo_pop, fifo_full;

  // Credit uses registered counts only, so a pop frees its slot one cycle
  // later. Reset also masks the grant so req_ready is zero while held.
  assign credit_sum = {1'b0, inflight_q} + {1'b0, fifo_count_q};
  assign credit_ok  = rst_n && (credit_sum < (CW + 1)'(FD));

  // Round-robin search starting at rr_ptr, first valid requester wins.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    grant_oh    = '0;
    arb_idx     = 0;
    for (int j = 0; j < NREQ; j++) begin
      arb_idx = int'(rr_ptr_q) + j;
      if (arb_idx >= NREQ) arb_idx = arb_idx - NREQ;
      if (credit_ok && !grant_found && bus.req_valid[arb_idx]) begin
        grant_found       = 1'b1;
        grant_id          = IDW'(arb_idx);
        grant_oh[arb_idx] = 1'b1;
      end
    end
  end

  assign bus.req_ready = grant_oh;
  assign accept        = grant_found;
  assign grant_a       = bus.req_a[int'(grant_id) * N +: N];
  assign grant_b       = bus.req_b[int'(grant_id) * N +: N];

  // Pointer moves just past the winner; unchanged when nobody is accepted.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept) begin
      rr_ptr_d = (int'(grant_id) == NREQ - 1) ? '0 : grant_id + IDW'(1);
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_ptr_q <= '0;
    else        rr_ptr_q <= rr_ptr_d;
  end

  // Issue register: one-cycle strobe, operands hold when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_valid_q <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      mul_id_q    <= '0;
    end else begin
      mul_valid_q <= accept;
      if (accept) begin
        mul_a_q  <= grant_a;
        mul_b_q  <= grant_b;
        mul_id_q <= grant_id;
      end
    end
  end

  assign mul_valid = mul_valid_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;

  // Tag pipeline: enters with mul_valid, its last stage lines up with the
  // cycle in which mul_result carries the matching product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_v_q <= '0;
      for (int i = 0; i < LAT; i++) tag_id_q[i] <= '0;
    end else begin
      tag_v_q[0]  <= mul_valid_q;
      tag_id_q[0] <= mul_id_q;
      for (int i = 1; i < LAT; i++) begin
        tag_v_q[i]  <= tag_v_q[i-1];
        tag_id_q[i] <= tag_id_q[i-1];
      end
    end
  end

  assign tag_out_v  = tag_v_q[LAT-1];
  assign tag_out_id = tag_id_q[LAT-1];

  assign fifo_wr   = tag_out_v;
  assign fifo_pop  = bus.rsp_valid && bus.rsp_ready;
  assign fifo_full = (fifo_count_q == CW'(FD));

  // Counter and pointer next-state, covering every write/pop and
  // accept/retire combination.
  always_comb begin
    inflight_d = inflight_q;
    case ({accept, tag_out_v})
      2'b10:   inflight_d = inflight_q + CW'(1);
      2'b01:   inflight_d = inflight_q - CW'(1);
      default: inflight_d = inflight_q;
    endcase

    fifo_count_d = fifo_count_q;
    case ({fifo_wr, fifo_pop})
      2'b10:   fifo_count_d = fifo_count_q + CW'(1);
      2'b01:   fifo_count_d = fifo_count_q - CW'(1);
      default: fifo_count_d = fifo_count_q;
    endcase

    wr_ptr_d = wr_ptr_q;
    if (fifo_wr) wr_ptr_d = (wr_ptr_q == PW'(FD - 1)) ? '0 : wr_ptr_q + PW'(1);

    rd_ptr_d = rd_ptr_q;
    if (fifo_pop) rd_ptr_d = (rd_ptr_q == PW'(FD - 1)) ? '0 : rd_ptr_q + PW'(1);
  end

  // Counter and pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q   <= '0;
      fifo_count_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else begin
      inflight_q   <= inflight_d;
      fifo_count_q <= fifo_count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
    end
  end

  // FIFO storage; cleared on reset so the head reads zero while empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FD; i++) begin
        fifo_data_q[i] <= '0;
        fifo_id_q[i]   <= '0;
      end
    end else if (fifo_wr) begin
      fifo_data_q[wr_ptr_q] <= mul_result;
      fifo_id_q[wr_ptr_q]   <= tag_out_id;
    end
  end

  assign bus.rsp_valid = (fifo_count_q != '0);
  assign bus.rsp_data  = fifo_data_q[rd_ptr_q];
  assign bus.rsp_id    = fifo_id_q[rd_ptr_q];
  assign busy          = (credit_sum != '0);

  // The credit check makes a write into a full, non-popping FIFO impossible.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(fifo_wr && fifo_full && !fifo_pop));

  // Outstanding work never exceeds the credit limit.
  a_credit_bound: assert property (@(posedge clk) disable iff (!rst_n)
    credit_sum <= (CW + 1)'(FD));

endmodule

// File: tb/tb_posit_mult_scheduler.sv
module tb_posit_mult_scheduler;
  localparam int N    = 32;
  localparam int NREQ = 4;
  localparam int LAT  = 2;
  localparam int FD   = 4;
  localparam int IDW  = $clog2(NREQ);

  logic         clk;
  logic         rst_n;
  logic         mul_valid;
  logic [N-1:0] mul_a, mul_b, mul_result;
  logic         busy;

  posit_mult_scheduler_if #(.N(N), .NREQ(NREQ), .IDW(IDW)) bus ();

  posit_mult_scheduler #(.N(N), .NREQ(NREQ), .LAT(LAT), .FD(FD), .IDW(IDW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .mul_valid  (mul_valid),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_result (mul_result),
    .busy       (busy)
  );

  // ---------------- clock / reset / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- posit<32,2> reference arithmetic ----------------
  function automatic void posit_decode(input logic [31:0] x, output int scale,
                                       output logic [28:0] frac);
    logic [31:0] ax;
    logic [30:0] r, rem;
    logic first;
    int m, k;
    ax = x[31] ? (~x + 32'd1) : x;
    r = ax[30:0];
    first = r[30];
    m = 0;
    for (int i = 30; i >= 0; i--) begin
      if (r[i] != first) break;
      m++;
    end
    k = first ? m - 1 : -m;
    rem = (m >= 30) ? '0 : (r << (m + 1));
    scale = 4 * k + int'(rem[30:29]);
    frac = rem[28:0];
  endfunction

  function automatic logic [31:0] posit_encode(input logic sign, input int scale,
                                               input logic [58:0] frac);
    logic [127:0] bits;
    logic [30:0]  body;
    logic         guard, sticky;
    logic [31:0]  res;
    int k, e, p;
    if (scale > 120) res = 32'h7FFF_FFFF;
    else if (scale < -120) res = 32'h0000_0001;
    else begin
      k = scale >>> 2;
      e = scale - 4 * k;
      bits = '0;
      p = 127;
      if (k >= 0) begin
        for (int i = 0; i <= k; i++) begin bits[p] = 1'b1; p--; end
        bits[p] = 1'b0; p--;
      end else begin
        for (int i = 0; i < -k; i++) begin bits[p] = 1'b0; p--; end
        bits[p] = 1'b1; p--;
      end
      bits[p] = e[1]; p--;
      bits[p] = e[0]; p--;
      for (int i = 58; i >= 0; i--) begin bits[p] = frac[i]; p--; end
      body   = bits[127:97];
      guard  = bits[96];
      sticky = |bits[95:0];
      if (guard && (sticky || body[0]) && body != '1) body = body + 31'd1;
      res = {1'b0, body};
      if (res == 32'd0) res = 32'd1;
    end
    if (sign) res = ~res + 32'd1;
    return res;
  endfunction

  function automatic logic [31:0] posit_mul(input logic [31:0] a, input logic [31:0] b);
    int sa, sb, sc;
    logic [28:0] fa, fb;
    logic [59:0] prod;
    logic [58:0] fr;
    if (a == 32'h8000_0000 || b == 32'h8000_0000) return 32'h8000_0000;
    if (a == 32'd0 || b == 32'd0) return 32'd0;
    posit_decode(a, sa, fa);
    posit_decode(b, sb, fb);
    prod = {1'b1, fa} * {1'b1, fb};
    sc = sa + sb;
    if (prod[59]) begin sc++; fr = prod[58:0]; end
    else fr = {prod[57:0], 1'b0};
    return posit_encode(a[31] ^ b[31], sc, fr);
  endfunction

  // ---------------- external datapath stand-in ----------------
  logic [N-1:0] dp_pipe [LAT];
  always @(posedge clk) begin
    dp_pipe[0] <= mul_valid ? posit_mul(mul_a, mul_b) : N'($urandom());
    for (int i = 1; i < LAT; i++) dp_pipe[i] <= dp_pipe[i-1];
  end
  assign mul_result = dp_pipe[LAT-1];

  // ---------------- requester state / driver tasks ----------------
  logic [NREQ-1:0] hold_v;
  logic [N-1:0]    hold_a [NREQ];
  logic [N-1:0]    hold_b [NREQ];
  logic [NREQ-1:0] acc_mask;

  task automatic pack();
    bus.req_valid = hold_v;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_a[i*N +: N] = hold_a[i];
      bus.req_b[i*N +: N] = hold_b[i];
    end
  endtask

  // One clock: retire accepted requests, raise new ones from 'want'.
  task automatic step(input logic [NREQ-1:0] want, input int pct, input logic rdy);
    @(posedge clk); #1;
    for (int i = 0; i < NREQ; i++) begin
      if (acc_mask[i]) hold_v[i] = 1'b0;
      if (!hold_v[i] && want[i] && int'($urandom_range(0, 99)) < pct) begin
        hold_v[i] = 1'b1;
        hold_a[i] = $urandom();
        hold_b[i] = $urandom();
      end
    end
    bus.rsp_ready = rdy;
    pack();
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    hold_v = '0;
    bus.rsp_ready = 1'b0;
    pack();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic drain();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      step('0, 0, 1'b1);
      @(negedge clk);
      if (!busy) done = 1'b1;
    end
    chk("drain_idle", done, 1);
  endtask

  // ---------------- scoreboard / reference model ----------------
  logic [N-1:0]   exp_q[$];
  logic [IDW-1:0] exp_id_q[$];
  int             exp_t_q[$];
  int outstanding = 0;
  int last_grant  = NREQ - 1;
  int mon_cyc     = 0;
  int acc_total   = 0;
  int grant_cnt [NREQ];

  // Round robin: first valid requester after the previous winner, gated by
  // total outstanding work (accepted but not yet consumed) below FD.
  function automatic logic [NREQ-1:0] model_grant(input logic [NREQ-1:0] v);
    int idx;
    if (outstanding >= FD) return '0;
    for (int j = 1; j <= NREQ; j++) begin
      idx = (last_grant + j) % NREQ;
      if (v[idx]) return NREQ'(1) << idx;
    end
    return '0;
  endfunction

  // Monitor: compare every output against the model, then advance it.
  always @(negedge clk) begin : monitor
    logic [NREQ-1:0] eg;
    logic erv;
    int g;
    if (!rst_n) begin
      chk("reset_outputs", |{bus.req_ready, mul_valid, mul_a, mul_b, bus.rsp_valid,
                             bus.rsp_data, bus.rsp_id, busy}, 0);
      exp_q.delete();
      exp_id_q.delete();
      exp_t_q.delete();
      outstanding = 0;
      last_grant  = NREQ - 1;
      acc_mask    = '0;
    end else begin
      mon_cyc++;
      eg = model_grant(bus.req_valid);
      chk("req_ready", bus.req_ready, eg);
      chk("busy", busy, outstanding != 0);
      erv = (exp_q.size() > 0) && (exp_t_q[0] <= mon_cyc);
      chk("rsp_valid", bus.rsp_valid, erv);
      if (erv && bus.rsp_valid) begin
        chk("rsp_data", bus.rsp_data, exp_q[0]);
        chk("rsp_id", bus.rsp_id, exp_id_q[0]);
      end
      acc_mask = eg;
      if (erv && bus.rsp_ready) begin
        void'(exp_q.pop_front());
        void'(exp_id_q.pop_front());
        void'(exp_t_q.pop_front());
        outstanding--;
      end
      if (eg != '0) begin
        g = 0;
        for (int i = 0; i < NREQ; i++) if (eg[i]) g = i;
        exp_q.push_back(posit_mul(bus.req_a[g*N +: N], bus.req_b[g*N +: N]));
        exp_id_q.push_back(IDW'(g));
        exp_t_q.push_back(mon_cyc + LAT + 2);
        outstanding++;
        last_grant = g;
        acc_total++;
        grant_cnt[g]++;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n, a0, c0, c2, seen;
    logic got;
    rst_n = 1'b0;
    hold_v = '0;
    acc_mask = '0;
    for (int i = 0; i < NREQ; i++) begin
      hold_a[i] = '0;
      hold_b[i] = '0;
      grant_cnt[i] = 0;
    end
    bus.rsp_ready = 1'b0;
    pack();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single request from requester 1: 1.0 * 2.0
    @(posedge clk); #1;
    hold_v[1] = 1'b1;
    hold_a[1] = 32'h4000_0000;
    hold_b[1] = 32'h4800_0000;
    bus.rsp_ready = 1'b1;
    pack();
    @(negedge clk);
    chk("dir_grant_r1", bus.req_ready, 4'b0010);
    n = 0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      step('0, 0, 1'b1);
      @(negedge clk);
      n++;
      if (bus.rsp_valid) got = 1'b1;
    end
    chk("dir_latency", n, LAT + 2);
    chk("dir_data", bus.rsp_data, 32'h4800_0000);
    chk("dir_id", bus.rsp_id, 1);

    // Requesters 0 and 2 continuously valid from rr_ptr=0
    do_reset();
    c0 = grant_cnt[0];
    c2 = grant_cnt[2];
    repeat (16) step(4'b0101, 100, 1'b1);
    @(negedge clk);
    chk("alt_r0_served", (grant_cnt[0] - c0) >= 5, 1);
    chk("alt_fair", ((grant_cnt[0] - c0) - (grant_cnt[2] - c2) + 1) <= 2, 1);

    // Back-pressure: credit exhaustion, then pop-before-accept resumption
    drain();
    a0 = acc_total;
    repeat (10) step(4'b1111, 100, 1'b0);
    @(negedge clk);
    chk("full_accepts", acc_total - a0, FD);
    chk("full_ready_low", bus.req_ready, 0);
    chk("full_busy", busy, 1);
    step(4'b1111, 100, 1'b1);
    @(negedge clk);
    chk("pop_cycle_rsp", bus.rsp_valid, 1);
    chk("pop_cycle_no_grant", bus.req_ready, 0);
    step(4'b1111, 100, 1'b1);
    @(negedge clk);
    chk("resume_grant", bus.req_ready != '0, 1);
    repeat (20) step(4'b1111, 100, 1'b1);

    // Pointer wrap: requester 3 alone, then requester 0 alone
    drain();
    step(4'b1000, 100, 1'b1);
    @(negedge clk);
    chk("wrap_r3", bus.req_ready, 4'b1000);
    step(4'b0001, 100, 1'b1);
    @(negedge clk);
    chk("wrap_r0", bus.req_ready, 4'b0001);

    // Random traffic with random consumer stalls
    repeat (400) step(NREQ'($urandom_range(0, 15)), 60, $urandom_range(0, 3) != 0);

    // Asynchronous reset inside the datapath latency window
    drain();
    step(4'b0110, 100, 1'b1);
    step('0, 0, 1'b1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    hold_v = '1;
    pack();
    #1;
    chk("async_reset_outputs", |{bus.req_ready, mul_valid, mul_a, mul_b, bus.rsp_valid,
                                 bus.rsp_data, bus.rsp_id, busy}, 0);
    repeat (2) @(posedge clk);
    hold_v = '0;
    pack();
    #1 rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      step('0, 0, 1'b1);
      @(negedge clk);
      if (bus.rsp_valid) seen++;
    end
    chk("no_rsp_after_reset", seen, 0);

    // Final short burst and drain
    repeat (30) step(NREQ'($urandom_range(0, 15)), 50, 1'b1);
    drain();
    chk("final_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/posit_mult_scheduler.md
Name: posit_mult_scheduler

Overview:
- Round-robin scheduler that shares one fixed-latency posit multiplier datapath between NREQ requesters.
- The datapath is the decode + multiply + encode chain, instantiated outside this block.
- The block owns arbitration, operand issue, in-flight tag tracking and credit-based result buffering.
- Completed products return to requesters in issue order, tagged with the originating requester ID.

Parameters:
- N, 32, posit word width.
- NREQ, 4, number of requesters (>=2).
- LAT, 2, datapath latency in cycles from mul_valid to mul_result (>=1).
- FD, 4, result FIFO depth; also the total credit limit (>=2).
- IDW, $clog2(NREQ), requester ID width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester operand valid.
- req_a  in  NREQ*N  operand A; requester i uses bits [i*N +: N].
- req_b  in  NREQ*N  operand B, same packing as req_a.
- req_ready  out  NREQ  one-hot grant; a transfer occurs when req_valid[i] and req_ready[i] are both high.
- mul_valid  out  1  registered issue strobe to the datapath.
- mul_a  out  N  registered operand A to the datapath.
- mul_b  out  N  registered operand B to the datapath.
- mul_result  in  N  datapath product; valid exactly LAT cycles after the matching mul_valid.
- rsp_valid  out  1  FIFO non-empty.
- rsp_ready  in  1  consumer accept.
- rsp_data  out  N  product at the FIFO head.
- rsp_id  out  IDW  requester ID at the FIFO head.
- busy  out  1  high when inflight+fifo_count != 0.

Behaviour:
- Clocking/reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - req_ready=0, mul_valid=0, mul_a=0, mul_b=0, rsp_valid=0, rsp_data=0, rsp_id=0, busy=0.
  - rr_ptr=0, inflight=0, fifo_count=0, tag pipeline valids all 0.
- Credit: issue is allowed when inflight+fifo_count < FD, using registered counts only. A pop in the same cycle does not free credit until the next cycle.
- Arbitration (combinational):
  - When issue is allowed, grant the first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... modulo NREQ.
  - req_ready is the one-hot of that grant; it is all-zero if there is no credit or no valid request.
  - req_ready may depend on req_valid.
  - Requesters must hold req_valid, req_a and req_b stable until accepted.
- rr_ptr update: on an accept, rr_ptr <= (granted+1) mod NREQ. With no accept, rr_ptr is unchanged. Wrap from NREQ-1 goes to 0.
- Issue: on an accept at edge E0:
  - mul_a/mul_b <= the granted operands and mul_valid <= 1 for one cycle.
  - With no accept, mul_valid <= 0 and mul_a/mul_b hold their values.
  - At most one issue per cycle; back-to-back issue every cycle is allowed.
- Tag pipeline: LAT-deep shift register of {valid, id}, entered alongside mul_valid. Its output marks the cycle in which mul_result is valid, i.e. LAT cycles after mul_valid.
- FIFO write: at the edge ending a tagged-valid result cycle, {mul_result, id} is written to the FIFO.
- Latency:
  - Accept edge to rsp_valid = LAT+2 cycles when the FIFO was empty.
  - With LAT=2: accept at edge 0 gives mul_valid in cycle 1, result in cycle 3, and rsp_valid in cycle 4.
- Overflow: the FIFO can never overflow because of the credit check. A write into a full FIFO is an assertion failure.
- Pop: a pop occurs when rsp_valid and rsp_ready are both high. The FIFO advances at that edge.
  - A simultaneous write and pop is legal at any fill level, including empty→empty-bypass-free (a write into an empty FIFO appears next cycle) and full-with-pop.
- Counters:
  - inflight += accept, -= tag-pipeline-output-valid.
  - fifo_count += write, -= pop.
  - All four combinations of events per cycle must be handled.
- Ordering: responses leave in accept order; the datapath order is preserved.
- Reset mid-operation: all in-flight and buffered results are discarded. The datapath is not flushed, but its results are ignored because the tag valids are cleared.

Test Plan:
- LAT=2, FD=4, single requester 1, a=0x40000000 (1.0), b=0x48000000 (2.0) -> req_ready=4'b0010 same cycle; rsp_valid 4 cycles after accept; rsp_data from the model (0x48000000); rsp_id=1.
- Requesters 0 and 2 held valid continuously, rr_ptr=0 -> grants alternate 0,2,0,2; rsp_id sequence 0,2,0,2; no requester starved.
- rsp_ready=0, all four requesters valid -> exactly 4 accepts, then req_ready=0 and busy=1. Raising rsp_ready resumes issue one cycle after the first pop.
- FIFO full, rsp_ready=1 and a requester valid in the same cycle -> pop occurs; no accept that cycle; accept occurs next cycle; fifo_count never exceeds 4.
- Two ops issued, rst_n pulsed low asynchronously during the LAT window -> all outputs 0 immediately; no rsp_valid after release even though the datapath emits results.
- NREQ=4, only requester 3 valid, then only requester 0 -> rr_ptr wraps 3->0 and requester 0 is granted immediately.
